// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg : shared types and constants for the UART word path      |
// | Rev 1.0  : initial release                                       |
// +------------------------------------------------------------------+
package uart_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_LOAD  = 4'b0010,
    ST_SEND  = 4'b0100,
    ST_GUARD = 4'b1000
  } sender_state_t;

  // Handshake bytes exchanged with the program loader
  localparam byte_t C_LOADER_ACK  = 8'h99;
  localparam byte_t C_LOADER_DONE = 8'haa;

  localparam logic [1:0] C_LAST_BYTE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_word_sender_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_word_sender_if : producer + UART-side bundle of the sender   |
// | Rev 1.0  : initial release                                       |
// +------------------------------------------------------------------+
interface uart_word_sender_if;
  import uart_pkg::*;

  logic  word_valid;
  word_t word_data;
  logic  word_ready;
  logic  tx_enable;
  logic  tx_busy;
  logic  tx_start;
  byte_t sdata;
  logic  pending;

  modport master (
    output word_valid, word_data, tx_enable, tx_busy,
    input  word_ready, tx_start, sdata, pending
  );

  modport slave (
    input  word_valid, word_data, tx_enable, tx_busy,
    output word_ready, tx_start, sdata, pending
  );

endinterface
`default_nettype wire

// File: rtl/uart_word_sender_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | word_fifo : show-ahead FIFO of 32-bit words (DEPTH power of two)  |
// | Rev 1.0  : initial release                                       |
// +------------------------------------------------------------------+
module word_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  wire logic  clock,
  input  wire logic  reset,
  input  wire logic  push,
  input  wire word_t din,
  input  wire logic  pop,
  output word_t      dout,
  output logic       full,
  output logic       empty
);

  localparam int C_AW = $clog2(DEPTH);

  word_t           r_mem [DEPTH];
  logic [C_AW:0]   r_wr_ptr;
  logic [C_AW:0]   r_rd_ptr;
  logic            w_do_push;
  logic            w_do_pop;

  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[C_AW-1:0]] <= din;
  end

  // Extra pointer bit distinguishes full from empty when the indices match
  assign dout  = r_mem[r_rd_ptr[C_AW-1:0]];
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                 (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/uart_word_sender.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_word_sender : buffers 32-bit words, sends them LSB byte first|
// | Option   : UART_WORD_SENDER_FIFO_EN selects FIFO vs holding reg   |
// | Rev 1.0  : initial release                                       |
// +------------------------------------------------------------------+
module uart_word_sender
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  wire logic          clock,
  input  wire logic          reset,
  uart_word_sender_if.slave  bus
);

  sender_state_t r_state;
  sender_state_t w_state_nxt;

  word_t       r_shift;
  word_t       w_shift_nxt;
  logic [1:0]  r_byte_idx;
  logic [1:0]  w_byte_idx_nxt;
  logic        r_tx_start;
  logic        w_tx_start_nxt;
  byte_t       r_sdata;
  byte_t       w_sdata_nxt;

  logic        w_buf_full;
  logic        w_buf_empty;
  word_t       w_buf_head;
  logic        w_push;
  logic        w_pop;

  assign w_push = bus.word_valid & ~w_buf_full;
  assign w_pop  = (r_state == ST_LOAD);

`ifdef UART_WORD_SENDER_FIFO_EN
  word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .din   (bus.word_data),
    .pop   (w_pop),
    .dout  (w_buf_head),
    .full  (w_buf_full),
    .empty (w_buf_empty)
  );
`else
  logic  r_hold_valid;
  word_t r_hold_data;

  // Push needs an empty register and pop a full one, so they never coincide
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (w_push) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= bus.word_data;
    end else if (w_pop) begin
      r_hold_valid <= 1'b0;
    end
  end

  assign w_buf_full  = r_hold_valid;
  assign w_buf_empty = ~r_hold_valid;
  assign w_buf_head  = r_hold_data;
`endif

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (!w_buf_empty && bus.tx_enable) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_SEND;
      ST_SEND:  if (!bus.tx_busy) w_state_nxt = ST_GUARD;
      ST_GUARD: w_state_nxt = (r_byte_idx == C_LAST_BYTE) ? ST_IDLE : ST_SEND;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // GUARD spends one cycle with tx_start low so a lagging tx_busy is seen in SEND
  always_comb begin
    w_tx_start_nxt = 1'b0;
    w_sdata_nxt    = r_sdata;
    w_shift_nxt    = r_shift;
    w_byte_idx_nxt = r_byte_idx;
    unique case (r_state)
      ST_LOAD: begin
        w_shift_nxt    = w_buf_head;
        w_byte_idx_nxt = 2'd0;
      end
      ST_SEND: begin
        if (!bus.tx_busy) begin
          w_tx_start_nxt = 1'b1;
          w_sdata_nxt    = r_shift[7:0];
        end
      end
      ST_GUARD: begin
        w_shift_nxt    = r_shift >> 8;
        w_byte_idx_nxt = r_byte_idx + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_start <= 1'b0;
      r_sdata    <= 8'h00;
      r_shift    <= '0;
      r_byte_idx <= 2'd0;
    end else begin
      r_tx_start <= w_tx_start_nxt;
      r_sdata    <= w_sdata_nxt;
      r_shift    <= w_shift_nxt;
      r_byte_idx <= w_byte_idx_nxt;
    end
  end

  assign bus.word_ready = ~w_buf_full;
  assign bus.tx_start   = r_tx_start;
  assign bus.sdata      = r_sdata;
  assign bus.pending    = ~w_buf_empty | (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_word_sender.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_word_sender : directed self-checking bench for the sender |
// | Rev 1.0  : initial release                                       |
// +------------------------------------------------------------------+
module tb_uart_word_sender;
  import uart_pkg::*;

  localparam int FIFO_DEPTH  = 16;
  localparam int BUSY_CYCLES = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;

  uart_word_sender_if bus ();

  uart_word_sender #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    b2b      = 0;
  int    busy_cnt = 0;
  logic  stuck    = 1'b0;
  logic  prev_start = 1'b0;
  byte_t rx_q[$];
  int    rx_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) cyc = cyc + 1;

  // UART model: busy for BUSY_CYCLES after each start; logs every byte sent
  always @(negedge clock) begin
    if (reset) begin
      busy_cnt   = 0;
      prev_start = 1'b0;
    end else begin
      if (bus.tx_start) begin
        rx_q.push_back(bus.sdata);
        rx_cyc.push_back(cyc);
        if (prev_start) b2b++;
      end
      prev_start = bus.tx_start;
      if (bus.tx_start)     busy_cnt = BUSY_CYCLES;
      else if (busy_cnt > 0) busy_cnt--;
    end
    bus.tx_busy = stuck || (busy_cnt != 0);
  end

  task automatic push_word(input word_t w, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clock);
    bus.word_valid = 1'b1;
    bus.word_data  = w;
    while (!bus.word_ready && n < 3000) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    acc_cyc = cyc;
    bus.word_valid = 1'b0;
    check("push_accepted", 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_bytes(input int target, input int budget);
    int n;
    n = 0;
    while (rx_q.size() < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("wait_bytes", 32'(rx_q.size() >= target), 32'd1);
  endtask

  task automatic check_word(input int base, input word_t w);
    for (int k = 0; k < 4; k++)
      check($sformatf("byte[%0d]", base + k), 32'(rx_q[base + k]), 32'(w[8*k +: 8]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    acc;
    int    base;
    int    snap;
    int    n;
    word_t w;

    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    bus.tx_enable  = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_tx_start", 32'(bus.tx_start),   32'd0);
    check("rst_sdata",    32'(bus.sdata),      32'h00);
    check("rst_pending",  32'(bus.pending),    32'd0);
    check("rst_ready",    32'(bus.word_ready), 32'd1);

    // Single word, latency and byte spacing
    bus.tx_enable = 1'b1;
    base = rx_q.size();
    push_word(32'h11223344, acc);
    wait_bytes(base + 4, 500);
    check_word(base, 32'h11223344);
    check("latency_first_start", 32'(rx_cyc[base] - acc), 32'd3);
    check("byte_gap", 32'(rx_cyc[base + 1] - rx_cyc[base]), 32'(BUSY_CYCLES + 1));
    repeat (20) @(negedge clock);
    check("idle_pending", 32'(bus.pending), 32'd0);
    check("no_extra_bytes", 32'(rx_q.size()), 32'(base + 4));

`ifdef UART_WORD_SENDER_FIFO_EN
    // Words held while disabled, released in order
    bus.tx_enable = 1'b0;
    base = rx_q.size();
    push_word(32'hA1A2A3A4, acc);
    push_word(32'hB1B2B3B4, acc);
    push_word(32'hC1C2C3C4, acc);
    repeat (50) @(negedge clock);
    check("disabled_no_tx", 32'(rx_q.size()), 32'(base));
    check("disabled_pending", 32'(bus.pending), 32'd1);
    bus.tx_enable = 1'b1;
    wait_bytes(base + 12, 1000);
    check_word(base,     32'hA1A2A3A4);
    check_word(base + 4, 32'hB1B2B3B4);
    check_word(base + 8, 32'hC1C2C3C4);

    // Fill to capacity with the UART stuck busy
    bus.tx_enable = 1'b0;
    stuck = 1'b1;
    base = rx_q.size();
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w = 32'h03020100 + 32'(i) * 32'h04040404;
      push_word(w, acc);
    end
    check("full_ready_low", 32'(bus.word_ready), 32'd0);
    bus.tx_enable = 1'b1;
    stuck = 1'b0;
    n = 0;
    while (!bus.word_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("ready_after_pop", 32'(bus.word_ready), 32'd1);
    wait_bytes(base + 4 * FIFO_DEPTH, 3000);
    for (int k = 0; k < 4 * FIFO_DEPTH; k++)
      check($sformatf("fill_byte[%0d]", k), 32'(rx_q[base + k]), 32'(k));
`else
    // Holding register: ready drops on accept until the word is loaded
    base = rx_q.size();
    @(negedge clock);
    check("hold_ready_before", 32'(bus.word_ready), 32'd1);
    bus.word_valid = 1'b1;
    bus.word_data  = 32'h87654321;
    @(negedge clock);
    bus.word_data  = 32'h0F1E2D3C;
    check("hold_ready_t1", 32'(bus.word_ready), 32'd0);
    @(negedge clock);
    check("hold_ready_t2", 32'(bus.word_ready), 32'd0);
    @(negedge clock);
    check("hold_ready_t3", 32'(bus.word_ready), 32'd1);
    @(negedge clock);
    check("hold_ready_t4", 32'(bus.word_ready), 32'd0);
    bus.word_valid = 1'b0;
    wait_bytes(base + 8, 500);
    check_word(base,     32'h87654321);
    check_word(base + 4, 32'h0F1E2D3C);
    repeat (20) @(negedge clock);
    check("hold_no_dup", 32'(rx_q.size()), 32'(base + 8));
`endif

    // Enable dropped mid-word: word finishes, next word waits
    bus.tx_enable = 1'b1;
    base = rx_q.size();
    push_word(32'hAABBCCDD, acc);
    wait_bytes(base + 2, 500);
    bus.tx_enable = 1'b0;
    push_word(32'h55667788, acc);
    wait_bytes(base + 4, 500);
    repeat (60) @(negedge clock);
    check("drop_en_count", 32'(rx_q.size()), 32'(base + 4));
    check_word(base, 32'hAABBCCDD);
    check("drop_en_pending", 32'(bus.pending), 32'd1);
    bus.tx_enable = 1'b1;
    wait_bytes(base + 8, 500);
    check_word(base + 4, 32'h55667788);

    // Reset mid-word discards everything
    base = rx_q.size();
    push_word(32'hCAFEF00D, acc);
    push_word(32'h01020304, acc);
`ifdef UART_WORD_SENDER_FIFO_EN
    push_word(32'h0A0B0C0D, acc);
`endif
    wait_bytes(base + 3, 500);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_tx_start", 32'(bus.tx_start),   32'd0);
    check("mid_rst_pending",  32'(bus.pending),    32'd0);
    check("mid_rst_ready",    32'(bus.word_ready), 32'd1);
    snap = rx_q.size();
    check("mid_rst_partial", 32'(snap), 32'(base + 3));
    repeat (100) @(negedge clock);
    check("mid_rst_silent", 32'(rx_q.size()), 32'(snap));
    push_word(32'h00000001, acc);
    wait_bytes(snap + 4, 500);
    check_word(snap, 32'h00000001);

    repeat (20) @(negedge clock);
    check("no_back_to_back", 32'(b2b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
